duty_button_conditioner: RTL and testbench
==========================================

# duty_button_conditioner

Conditions two raw push-button inputs into clean single-cycle increase/decrease-duty strobes for the PWM generator. It sits directly upstream of `pwm` and drives its `i_increase_duty` / `i_decrease_duty` inputs. Each channel has a 2-flop synchronizer, a counter-based debouncer, a press-edge strobe and an optional hold-to-repeat. Simultaneous presses are locked out so the PWM never sees conflicting requests.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive cycles a synchronized level must differ from the stable level before it is accepted (≥2).
- `REPEAT_EN`, 1: 1 enables hold-to-repeat; 0 gives exactly one strobe per press.
- `REPEAT_DELAY`, 64: cycles from the first strobe to the first repeat strobe (≥2).
- `REPEAT_PERIOD`, 32: cycles between subsequent repeat strobes (≥2).
- `i_clk`  in  1  system clock (100 MHz in the bench); all logic is on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_btn_inc`  in  1  raw, asynchronous, bouncy "increase" button (1 = pressed).
- `i_btn_dec`  in  1  raw, asynchronous, bouncy "decrease" button (1 = pressed).
- `o_increase_duty`  out  1  one-cycle strobe, connects to `pwm.i_increase_duty`.
- `o_decrease_duty`  out  1  one-cycle strobe, connects to `pwm.i_decrease_duty`.

## Operation
- Each channel is identical and independent, apart from the lockout rule below.
- **Synchronizer:** raw input → `sync1` → `sync2` (`s`).
- **Debouncer:** stable level `d` and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
  - If `s == d`: `cnt <= 0`.
  - If `s != d` and `cnt == DEBOUNCE_CYCLES-1`: `d <= s`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any return of `s` to `d` before the terminal count discards the count.
- **Per-channel FSM (IDLE, HOLD, REPEAT, LOCKOUT)** with repeat counter `rc`, wide enough for max(`REPEAT_DELAY`, `REPEAT_PERIOD`):
  - IDLE, `d` rises, other channel's `d` = 0: strobe = 1, `rc <= 0`, go HOLD.
  - IDLE, `d` rises, other channel's `d` = 1: go LOCKOUT, no strobe.
  - HOLD: `rc` increments. If `REPEAT_EN` and `rc == REPEAT_DELAY-1`: strobe, `rc <= 0`, go REPEAT.
  - REPEAT: `rc` increments. At `rc == REPEAT_PERIOD-1`: strobe, `rc <= 0`.
  - Any of HOLD/REPEAT: own `d` = 0 → IDLE, no strobe, same cycle.
  - Any of HOLD/REPEAT: other channel's `d` = 1 → LOCKOUT, no strobe. Own-release has priority over lockout.
  - LOCKOUT: no strobes. Leaves to IDLE only when own `d` = 0, so a new press is required.
- **Strobes:** outputs are registered and high for exactly one cycle. `o_increase_duty` and `o_decrease_duty` are never high in the same cycle.
- **Reset:** `sync1`, `sync2`, `d`, `cnt`, `rc` = 0; FSMs = IDLE; both outputs = 0 from the first edge with `i_rst` = 1.
  - Reset mid-operation drops any pending strobe or repeat.
  - A button still held when reset releases is treated as a fresh press and strobes after the full latency.

## Timing
- **Press latency:** raw input goes 1 before edge E0 and stays clean. `s` = 1 after E0+1. `d` = 1 after E0+1+`DEBOUNCE_CYCLES`. Strobe is high for the cycle following edge E0+2+`DEBOUNCE_CYCLES`. Default: 18 edges after E0.
- **Release:** `d` falls `DEBOUNCE_CYCLES`+2 edges after the raw fall; no strobe is produced on release.
- **Glitch rejection:** a pulse or bounce gap at `s` of at most `DEBOUNCE_CYCLES-1` cycles never changes `d`.
- **Repeat spacing:** first repeat strobe is `REPEAT_DELAY` cycles after the press strobe. Later strobes are every `REPEAT_PERIOD` cycles, measured rising edge to rising edge.
- **Simultaneous press:** both `d` rise on the same edge → both channels go LOCKOUT with zero strobes.

## Test plan
- **Clean press:** defaults; `i_btn_inc` 0→1 held 30 cycles then released → exactly one `o_increase_duty` strobe, 18 cycles after the press, 1 cycle wide; `o_decrease_duty` stays 0.
- **Bounce rejection:** `i_btn_dec` toggles in 15-cycle high / 5-cycle low bursts for 200 cycles → zero strobes. Then held high 40 cycles → exactly one strobe.
- **Hold-repeat:** `i_btn_inc` held 200 cycles after debounce → strobes at press-strobe cycle T, T+64, T+96, T+128, T+160, T+192. After release: none. With `REPEAT_EN`=0, same stimulus → only T.
- **Conflict:** `i_btn_inc` held, then `i_btn_dec` pressed 50 cycles later and both held 200 cycles → one inc strobe, zero dec strobes, no inc repeats after dec debounces. Release dec, keep inc held → still no inc strobes until inc is re-pressed.
- **Reset mid-hold:** during inc REPEAT, assert `i_rst` for 3 cycles → outputs 0 from the next edge. Inc still held after release → one strobe 18 cycles after reset deasserts, then the repeat cadence restarts.
- **Integration with pwm:** three inc presses then three dec presses, 100 ns apart each, with `DEBOUNCE_CYCLES`=2 → `pwm` receives exactly 3 inc and 3 dec single-cycle strobes and returns to its original duty.

Source files
------------

// File: rtl/duty_button_conditioner.sv
// Turns the raw "increase" and "decrease" push-buttons into one-cycle duty strobes for the pwm block.
// Each channel synchronizes, debounces, edge-detects, optionally repeats, and locks out when both buttons are pressed.
module duty_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_inc,
  input  logic i_btn_dec,
  output logic o_increase_duty,
  output logic o_decrease_duty
);

  localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST      = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RC_DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RC_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_REPEAT  = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  // Bit 0 is the increase channel, bit 1 the decrease channel.
  logic [1:0] raw_vec;
  logic [1:0] d_vec;
  logic [1:0] strobe_vec;

  assign raw_vec = {i_btn_dec, i_btn_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic          sync1_reg;
      logic          sync2_reg;
      logic          d_reg;
      logic [CW-1:0] cnt_reg;
      logic [1:0]    state_reg;
      logic [1:0]    state_next;
      logic [RW-1:0] rc_reg;
      logic [RW-1:0] rc_next;
      logic          strobe_reg;
      logic          strobe_next;
      logic          other_d;

      assign other_d = (gi == 0) ? d_vec[1] : d_vec[0];

      // A change of level is accepted only after it persists for the full count.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          d_reg     <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_vec[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == d_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            d_reg   <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      // Own release wins over lockout; lockout is left only after release so a new press is needed.
      always_comb begin
        state_next  = state_reg;
        rc_next     = rc_reg;
        strobe_next = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (d_reg) begin
              if (other_d) begin
                state_next = ST_LOCKOUT;
              end else begin
                strobe_next = 1'b1;
                rc_next     = '0;
                state_next  = ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (!d_reg) begin
              state_next = ST_IDLE;
              rc_next    = '0;
            end else if (other_d) begin
              state_next = ST_LOCKOUT;
              rc_next    = '0;
            end else if ((REPEAT_EN != 0) && (rc_reg == RC_DELAY_LAST)) begin
              strobe_next = 1'b1;
              rc_next     = '0;
              state_next  = ST_REPEAT;
            end else begin
              rc_next = rc_reg + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!d_reg) begin
              state_next = ST_IDLE;
              rc_next    = '0;
            end else if (other_d) begin
              state_next = ST_LOCKOUT;
              rc_next    = '0;
            end else if (rc_reg == RC_PERIOD_LAST) begin
              strobe_next = 1'b1;
              rc_next     = '0;
            end else begin
              rc_next = rc_reg + 1'b1;
            end
          end
          ST_LOCKOUT: begin
            if (!d_reg) begin
              state_next = ST_IDLE;
            end
          end
          default: begin
            state_next = ST_IDLE;
            rc_next    = '0;
          end
        endcase
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_reg  <= ST_IDLE;
          rc_reg     <= '0;
          strobe_reg <= 1'b0;
        end else begin
          state_reg  <= state_next;
          rc_reg     <= rc_next;
          strobe_reg <= strobe_next;
        end
      end

      assign d_vec[gi]      = d_reg;
      assign strobe_vec[gi] = strobe_reg;
    end
  endgenerate

  // Lockout guarantees a strobe only fires while the other channel is released, so the two never overlap.
  assign o_increase_duty = strobe_vec[0];
  assign o_decrease_duty = strobe_vec[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Directed bench for duty_button_conditioner: press latency, bounce rejection, repeat cadence,
// lockout, reset mid-hold, and a short-debounce instance feeding a duty-counter model.
module tb_duty_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_inc = 1'b0;
  logic btn_dec = 1'b0;
  logic f_inc = 1'b0;
  logic f_dec = 1'b0;
  logic inc, dec, nr_inc, nr_dec, fa_inc, fa_dec;

  duty_button_conditioner dut (
    .i_clk(clk), .i_rst(rst), .i_btn_inc(btn_inc), .i_btn_dec(btn_dec),
    .o_increase_duty(inc), .o_decrease_duty(dec)
  );

  duty_button_conditioner #(.REPEAT_EN(0)) dut_nr (
    .i_clk(clk), .i_rst(rst), .i_btn_inc(btn_inc), .i_btn_dec(btn_dec),
    .o_increase_duty(nr_inc), .o_decrease_duty(nr_dec)
  );

  duty_button_conditioner #(.DEBOUNCE_CYCLES(2)) dut_fast (
    .i_clk(clk), .i_rst(rst), .i_btn_inc(f_inc), .i_btn_dec(f_dec),
    .o_increase_duty(fa_inc), .o_decrease_duty(fa_dec)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log: cycle stamps per output, plus width/overlap violations and a pwm duty model.
  int inc_t[$];
  int dec_t[$];
  int nr_inc_t[$];
  int nr_dec_t[$];
  int fa_inc_n = 0;
  int fa_dec_n = 0;
  int duty = 50;
  int wide = 0;
  int both = 0;
  logic prev_inc = 1'b0;
  logic prev_dec = 1'b0;

  always @(negedge clk) begin
    if (inc) inc_t.push_back(cyc);
    if (dec) dec_t.push_back(cyc);
    if (nr_inc) nr_inc_t.push_back(cyc);
    if (nr_dec) nr_dec_t.push_back(cyc);
    if (inc && prev_inc) wide++;
    if (dec && prev_dec) wide++;
    if (inc && dec) both++;
    if (fa_inc && fa_dec) both++;
    prev_inc = inc;
    prev_dec = dec;
    if (fa_inc) begin
      fa_inc_n++;
      if (duty < 100) duty++;
    end
    if (fa_dec) begin
      fa_dec_n++;
      if (duty > 0) duty--;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t, tr, b0, bd, bn, fi, fd;
    int offs[6];
    offs = '{0, 64, 96, 128, 160, 192};

    // Reset: outputs low from the first edge.
    step(1);
    chk("rst_inc", int'(inc), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_fast_inc", int'(fa_inc), 0);
    step(2);
    rst = 1'b0;
    step(5);

    // Clean press: one strobe 18 edges after the press edge.
    b0 = inc_t.size(); bd = dec_t.size(); bn = nr_inc_t.size();
    btn_inc = 1'b1; t = cyc;
    step(30);
    btn_inc = 1'b0;
    step(40);
    chk("press_cnt", inc_t.size() - b0, 1);
    chk("press_time", inc_t[b0], t + 19);
    chk("press_dec_quiet", dec_t.size() - bd, 0);
    chk("press_nr_cnt", nr_inc_t.size() - bn, 1);
    $display("press: inc strobes=%0d at cycle %0d", inc_t.size() - b0, inc_t[b0]);

    // Bounce bursts of 15 high / 5 low never debounce.
    b0 = inc_t.size(); bd = dec_t.size();
    for (int k = 0; k < 10; k++) begin
      btn_dec = 1'b1;
      step(15);
      btn_dec = 1'b0;
      step(5);
    end
    chk("bounce_dec", dec_t.size() - bd, 0);
    chk("bounce_inc", inc_t.size() - b0, 0);
    btn_dec = 1'b1; t = cyc;
    step(40);
    btn_dec = 1'b0;
    step(40);
    chk("bounce_hold_cnt", dec_t.size() - bd, 1);
    chk("bounce_hold_time", dec_t[bd], t + 19);
    $display("bounce: dec strobes=%0d", dec_t.size() - bd);

    // Hold-repeat: T, T+64, then every 32.
    b0 = inc_t.size(); bn = nr_inc_t.size();
    btn_inc = 1'b1; t = cyc;
    step(220);
    btn_inc = 1'b0;
    step(60);
    chk("repeat_cnt", inc_t.size() - b0, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("repeat_t%0d", k), inc_t[b0 + k], t + 19 + offs[k]);
    chk("norepeat_cnt", nr_inc_t.size() - bn, 1);
    chk("norepeat_time", nr_inc_t[bn], t + 19);
    $display("repeat: inc strobes=%0d, no-repeat strobes=%0d", inc_t.size() - b0, nr_inc_t.size() - bn);

    // Conflict: dec pressed while inc held locks both out.
    b0 = inc_t.size(); bd = dec_t.size();
    btn_inc = 1'b1; t = cyc;
    step(50);
    btn_dec = 1'b1;
    step(200);
    chk("conflict_inc_cnt", inc_t.size() - b0, 1);
    chk("conflict_inc_time", inc_t[b0], t + 19);
    chk("conflict_dec_cnt", dec_t.size() - bd, 0);
    btn_dec = 1'b0;
    step(60);
    chk("lockout_inc_cnt", inc_t.size() - b0, 1);
    btn_inc = 1'b0;
    step(40);
    btn_inc = 1'b1; t = cyc;
    step(30);
    btn_inc = 1'b0;
    step(40);
    chk("repress_cnt", inc_t.size() - b0, 2);
    chk("repress_time", inc_t[b0 + 1], t + 19);
    chk("conflict_dec_end", dec_t.size() - bd, 0);
    $display("conflict: inc strobes=%0d dec strobes=%0d", inc_t.size() - b0, dec_t.size() - bd);

    // Reset in the middle of repeating drops the pending repeat; held button restarts.
    b0 = inc_t.size();
    btn_inc = 1'b1; t = cyc;
    step(100);
    rst = 1'b1;
    step(1);
    chk("midrst_inc", int'(inc), 0);
    step(2);
    rst = 1'b0; tr = cyc;
    step(90);
    btn_inc = 1'b0;
    step(40);
    chk("midrst_cnt", inc_t.size() - b0, 4);
    chk("midrst_t0", inc_t[b0], t + 19);
    chk("midrst_t1", inc_t[b0 + 1], t + 83);
    chk("midrst_t2", inc_t[b0 + 2], tr + 19);
    chk("midrst_t3", inc_t[b0 + 3], tr + 83);
    $display("reset mid-hold: inc strobes=%0d", inc_t.size() - b0);

    // Short-debounce instance: 3 inc then 3 dec presses bring duty back to start.
    fi = fa_inc_n; fd = fa_dec_n;
    for (int k = 0; k < 3; k++) begin
      f_inc = 1'b1;
      step(5);
      f_inc = 1'b0;
      step(5);
    end
    for (int k = 0; k < 3; k++) begin
      f_dec = 1'b1;
      step(5);
      f_dec = 1'b0;
      step(5);
    end
    step(20);
    chk("pwm_inc_cnt", fa_inc_n - fi, 3);
    chk("pwm_dec_cnt", fa_dec_n - fd, 3);
    chk("pwm_duty", duty, 50);
    $display("pwm: inc=%0d dec=%0d duty=%0d", fa_inc_n - fi, fa_dec_n - fd, duty);

    // Whole-run properties.
    chk("strobe_width", wide, 0);
    chk("strobe_overlap", both, 0);
    chk("dec_total", dec_t.size(), 1);
    chk("nr_dec_total", nr_dec_t.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
